pio_edge_intr_ctrl: RTL and testbench

Parametrised Avalon-MM input PIO with per-bit synchroniser, programmable digital debounce, separate rising- and falling-edge capture enables, per-bit interrupt mask, and selectable level/edge interrupt source. It is the next-generation replacement for the single-bit pen-interrupt PIO and serves touch-pen, key and switch inputs on the platform interconnect. Edge-capture bits are write-1-to-clear, so software can service each bit independently.

---
 rtl/pio_edge_intr_ctrl.sv | 137 +++++++++++++
 tb/tb_pio_edge_intr_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_intr_ctrl.sv
// Avalon-MM input PIO: per-bit synchroniser, debounce, rise/fall edge capture
// (write-1-to-clear) and a masked level/edge interrupt.
module pio_edge_intr_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] A_DATA = 3'd0, A_RISE = 3'd1, A_MASK = 3'd2, A_EDGE = 3'd3,
                         A_FALL = 3'd4, A_MODE = 3'd5, A_THR  = 3'd6, A_RAW  = 3'd7;

  // Bus access: a write happens on any edge with chipselect=1 and write_n=0;
  // there are no wait states, and readdata holds the register selected by
  // address on the previous edge (chipselect is not needed for reads).
  logic wr_en;
  assign wr_en = chipselect & ~write_n;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [DB_W-1:0]  cnt_q  [WIDTH];
  logic [DB_W-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             irq_mode_q, irq_mode_d;
  logic [DB_W-1:0]  db_thr_q, db_thr_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_set, edge_clr;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // cnt only increments while below the threshold, so it can never wrap.
  always_comb begin
    filt_d = filt_q;
    upd    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != filt_q[i]) begin
        if (cnt_q[i] >= db_thr_q) begin
          filt_d[i] = sync[i];
          upd[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_mask_d = irq_mask_q;
    irq_mode_d = irq_mode_q;
    db_thr_d   = db_thr_q;
    edge_clr   = '0;
    if (wr_en) begin
      case (address)
        A_RISE:  rise_en_d  = writedata[WIDTH-1:0];
        A_MASK:  irq_mask_d = writedata[WIDTH-1:0];
        A_EDGE:  edge_clr   = writedata[WIDTH-1:0];
        A_FALL:  fall_en_d  = writedata[WIDTH-1:0];
        A_MODE:  irq_mode_d = writedata[0];
        A_THR:   db_thr_d   = writedata[DB_W-1:0];
        default: ;
      endcase
    end
    // A capture on the same edge as a clear of that bit wins.
    edge_set   = upd & ((sync & rise_en_q) | (~sync & fall_en_q));
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      A_DATA:  readdata_d[WIDTH-1:0] = filt_q;
      A_RISE:  readdata_d[WIDTH-1:0] = rise_en_q;
      A_MASK:  readdata_d[WIDTH-1:0] = irq_mask_q;
      A_EDGE:  readdata_d[WIDTH-1:0] = edge_cap_q;
      A_FALL:  readdata_d[WIDTH-1:0] = fall_en_q;
      A_MODE:  readdata_d[0]         = irq_mode_q;
      A_THR:   readdata_d[DB_W-1:0]  = db_thr_q;
      A_RAW:   readdata_d[WIDTH-1:0] = sync;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_mode_q <= 1'b0;
      db_thr_q   <= '0;
      readdata_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      filt_q     <= filt_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_mode_q <= irq_mode_d;
      db_thr_q   <= db_thr_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(irq_mask_q & (irq_mode_q ? filt_q : edge_cap_q));

endmodule

// File: tb/tb_pio_edge_intr_ctrl.sv
// Bench for pio_edge_intr_ctrl: register table, debounce timing, edge capture,
// W1C collisions, level mode, threshold change and asynchronous reset.
module tb_pio_edge_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[9];

  pio_edge_intr_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DB_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    logic [31:0] ex;
    string       n;
    address = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick(1);
    ex = exp_q.pop_front();
    n  = name_q.pop_front();
    total++;
    if (readdata !== ex) begin
      bad++;
      $display("FAIL %s: readdata got %h, required %h", n, readdata, ex);
    end
  endtask

  task automatic chk_irq(input logic e, input string nm);
    total++;
    if (irq !== e) begin
      bad++;
      $display("FAIL %s: irq got %b, required %b", nm, irq, e);
    end
  endtask

  initial begin
    vecs[0] = '{3'd1, 32'h0000_00A5, 32'h0000_00A5, "rise_en_rw"};
    vecs[1] = '{3'd1, 32'h0000_01FF, 32'h0000_00FF, "rise_en_trunc"};
    vecs[2] = '{3'd2, 32'h0000_0081, 32'h0000_0081, "irq_mask_rw"};
    vecs[3] = '{3'd4, 32'h0000_003C, 32'h0000_003C, "fall_en_rw"};
    vecs[4] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, "irq_mode_bit0"};
    vecs[5] = '{3'd6, 32'h0001_2345, 32'h0000_2345, "db_thr_trunc"};
    vecs[6] = '{3'd0, 32'h0000_0012, 32'h0000_00FF, "data_ro"};
    vecs[7] = '{3'd7, 32'h0000_0000, 32'h0000_00FF, "raw_ro"};
    vecs[8] = '{3'd3, 32'h0000_00FF, 32'h0000_0000, "edge_cap_empty"};

    // reset release with inputs held high, RISE_EN=0
    in_port = 8'hFF;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    rd(3'd0, 32'h0, "data_before_latency");
    rd(3'd0, 32'hFF, "data_at_latency");
    rd(3'd3, 32'h0, "edge_cap_after_reset");
    chk_irq(1'b0, "irq_after_reset");

    // register table
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    wr(3'd6, 32'h0);
    wr(3'd1, 32'h0); wr(3'd2, 32'h0); wr(3'd4, 32'h0); wr(3'd5, 32'h0);
    in_port = 8'h00;
    tick(6);
    wr(3'd3, 32'hFF);
    rd(3'd0, 32'h0, "data_cleared");

    // debounce: 10-cycle glitch rejected, 11-cycle pulse accepted at 13
    wr(3'd6, 32'd10);
    wr(3'd1, 32'h01);
    in_port[0] = 1'b1; tick(10); in_port[0] = 1'b0;
    tick(20);
    rd(3'd0, 32'h0, "glitch_data");
    rd(3'd3, 32'h0, "glitch_edge");
    in_port[0] = 1'b1; tick(11); in_port[0] = 1'b0;
    tick(1);
    rd(3'd0, 32'h0, "pulse_data_cycle12");
    rd(3'd0, 32'h1, "pulse_data_cycle13");
    rd(3'd3, 32'h1, "pulse_edge");
    chk_irq(1'b0, "pulse_irq_unmasked");
    tick(30);
    wr(3'd3, 32'hFF);

    // edge selection
    wr(3'd6, 32'd0);
    wr(3'd1, 32'h01); wr(3'd4, 32'h02); wr(3'd2, 32'h03);
    in_port[1] = 1'b1; tick(5);
    rd(3'd3, 32'h0, "bit1_rise_ignored");
    chk_irq(1'b0, "bit1_rise_irq");
    in_port[1] = 1'b0; tick(5);
    rd(3'd3, 32'h02, "bit1_fall_captured");
    chk_irq(1'b1, "bit1_fall_irq");
    wr(3'd3, 32'h02);
    chk_irq(1'b0, "w1c_irq_drop");
    rd(3'd3, 32'h0, "w1c_cleared");

    // collision: W1C of bit0 on the capture edge
    in_port[0] = 1'b1; tick(2);
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h01, "collision_set_wins");
    chk_irq(1'b1, "collision_irq");
    wr(3'd1, 32'h05);
    in_port[2] = 1'b1; tick(5);
    rd(3'd3, 32'h05, "two_pending");
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h04, "w1c_only_bit0");
    chk_irq(1'b0, "bit2_pending_unmasked");

    // level mode
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'h1); wr(3'd2, 32'h80);
    chk_irq(1'b0, "level_idle");
    in_port[7] = 1'b1; tick(5);
    chk_irq(1'b1, "level_high");
    wr(3'd3, 32'hFF);
    chk_irq(1'b1, "level_w1c_no_effect");
    in_port[7] = 1'b0; tick(2);
    chk_irq(1'b1, "level_before_latency");
    tick(1);
    chk_irq(1'b0, "level_dropped");

    // lower DB_THR from 1000 to 5 with cnt at 200
    wr(3'd6, 32'd1000);
    in_port[6] = 1'b1; tick(201);
    wr(3'd6, 32'd5);
    rd(3'd0, 32'h05, "thr_lower_before");
    rd(3'd0, 32'h45, "thr_lower_after");

    // asynchronous reset mid-count
    wr(3'd6, 32'd100);
    wr(3'd4, 32'hFF);
    in_port[3] = 1'b1; tick(20);
    address = 3'd6; tick(1);
    rd(3'd6, 32'd100, "thr_before_reset");
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++;
      $display("FAIL async_reset_readdata: got %h, required 0", readdata);
    end
    chk_irq(1'b0, "async_reset_irq");
    in_port = 8'h00;
    tick(2);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 32'h0, $sformatf("post_reset_reg%0d", a));
    end
    chk_irq(1'b0, "post_reset_irq");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
